// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small power-of-two transmit FIFO.
// A new frame starts straight from the stop bit when more data is queued.
module uart_tx #(
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned FREQUENCY_IN_HZ = 100_000_000;
  localparam int unsigned BAUD_COUNT      = FREQUENCY_IN_HZ / BAUD;
  localparam int unsigned CntW = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW-1:0] CycLast   = CntW'(BAUD_COUNT - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]   cyc_q, cyc_d;
  logic              tx_q, tx_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic push, pop, full, empty, bit_done;

  assign full       = (count_q == CountFull);
  assign empty      = (count_q == '0);
  assign data_ready = !full;
  assign push       = data_valid && !full;
  assign bit_done   = (cyc_q == CycLast);
  assign busy       = (state_q != StIdle) || !empty;
  assign tx         = tx_q;

  // FIFO bookkeeping; pointers wrap naturally because depth is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_d     = cyc_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          cyc_d     = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          cyc_d   = '0;
          state_d = StData;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StData: begin
        if (bit_done) begin
          cyc_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          cyc_d = '0;
          if (!empty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_cnt_d = '0;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is derived from the next state so tx comes straight off a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_q     <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_q     <= cyc_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default-rate instance and a 1 Mbaud instance, each with a
// serial receiver that decodes frames and checks them against a byte queue.
module tb_uart_tx;

  logic       clk;
  logic       rst_a, valid_a, ready_a, tx_a, busy_a;
  logic       rst_b, valid_b, ready_b, tx_b, busy_b;
  logic [7:0] data_a, data_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  uart_tx u_slow (
    .clk        (clk),
    .rst        (rst_a),
    .data       (data_a),
    .data_valid (valid_a),
    .data_ready (ready_a),
    .tx         (tx_a),
    .busy       (busy_a)
  );

  uart_tx #(
    .BAUD       (1_000_000),
    .FIFO_DEPTH (4)
  ) u_fast (
    .clk        (clk),
    .rst        (rst_b),
    .data       (data_b),
    .data_valid (valid_b),
    .data_ready (ready_b),
    .tx         (tx_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic rst_of(input bit sel);
    return sel ? rst_b : rst_a;
  endfunction

  // Issue one write on the next edge; expected bytes go to the scoreboard now.
  task automatic wr(input bit sel, input logic [7:0] b, input bit expect_it);
    if (sel) begin
      data_b = b; valid_b = 1'b1;
      if (expect_it) q_b.push_back(b);
    end else begin
      data_a = b; valid_a = 1'b1;
      if (expect_it) q_a.push_back(b);
    end
    @(posedge clk);
    #1;
    if (sel) begin valid_b = 1'b0; data_b = 'x; end
    else     begin valid_a = 1'b0; data_a = 'x; end
  endtask

  task automatic skip(input bit sel, input int n, output bit ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (rst_of(sel) !== 1'b1) ab = 1'b1;
    end
  endtask

  // Receiver: finds a start bit, samples mid-bit, drops frames cut by reset.
  task automatic rx_mon(input bit sel);
    int bc;
    bit ab, a2, have;
    logic st, sp;
    logic [7:0] b, e;
    bc = sel ? 100 : 868;
    forever begin
      @(negedge clk);
      if (rst_of(sel) === 1'b1 && line_of(sel) === 1'b0) begin
        skip(sel, bc / 2, ab);
        st = line_of(sel);
        for (int i = 0; i < 8; i++) begin
          skip(sel, bc, a2);
          ab |= a2;
          b[i] = line_of(sel);
        end
        skip(sel, bc, a2);
        ab |= a2;
        sp = line_of(sel);
        if (!ab) begin
          chk(sel ? "rx_b_start" : "rx_a_start", {31'd0, st}, 32'd0);
          chk(sel ? "rx_b_stop" : "rx_a_stop", {31'd0, sp}, 32'd1);
          have = 1'b1;
          e = '0;
          if (sel) begin
            if (q_b.size() == 0) have = 1'b0; else e = q_b.pop_front();
          end else begin
            if (q_a.size() == 0) have = 1'b0; else e = q_a.pop_front();
          end
          if (!have) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected_frame: got byte %0h want none (inst %0d)", b, sel);
          end else begin
            chk(sel ? "rx_b_byte" : "rx_a_byte", {24'd0, b}, {24'd0, e});
          end
        end
      end
    end
  endtask

  initial rx_mon(1'b0);
  initial rx_mon(1'b1);

  task automatic wait_idle_b(input int limit);
    int n = 0;
    while (busy_b !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("fast_goes_idle", {31'd0, busy_b}, 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int n;
    bit quiet;
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = 'x; data_b = 'x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_a", {31'd0, tx_a}, 32'd1);
    chk("reset_busy_a", {31'd0, busy_a}, 32'd0);
    chk("reset_ready_a", {31'd0, ready_a}, 32'd1);
    chk("reset_tx_b", {31'd0, tx_b}, 32'd1);
    chk("reset_busy_b", {31'd0, busy_b}, 32'd0);
    chk("reset_ready_b", {31'd0, ready_b}, 32'd1);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (5) @(negedge clk);

    // Single 0x55 frame, bit-exact timing at default baud.
    v = 8'h55;
    wr(1'b0, v, 1'b1);
    for (int j = 0; j <= 8681; j++) begin
      @(negedge clk);
      if (j == 0) chk("b55_tx_before_start", {31'd0, tx_a}, 32'd1);
      if (j == 0) chk("b55_busy_on_accept", {31'd0, busy_a}, 32'd1);
      if (j == 1 || j == 868) chk("b55_start_bit", {31'd0, tx_a}, 32'd0);
      if (j >= 869 && j < 7813 && ((j - 869) % 868 == 0 || (j - 869) % 868 == 867))
        chk("b55_data_bit", {31'd0, tx_a}, {31'd0, v[(j - 869) / 868]});
      if (j == 7813 || j == 8680) chk("b55_stop_bit", {31'd0, tx_a}, 32'd1);
      if (j == 8680) chk("b55_busy_last", {31'd0, busy_a}, 32'd1);
      if (j == 8681) chk("b55_busy_clear", {31'd0, busy_a}, 32'd0);
    end
    repeat (10) @(negedge clk);

    // Four back-to-back bytes: contiguous frames, 34720 cycles end to end.
    wr(1'b0, 8'h01, 1'b1);
    wr(1'b0, 8'h80, 1'b1);
    wr(1'b0, 8'hFF, 1'b1);
    wr(1'b0, 8'h00, 1'b1);
    for (int j = 3; j <= 34721; j++) begin
      @(negedge clk);
      if (j == 8680 || j == 17360) chk("b2b_stop_before_next", {31'd0, tx_a}, 32'd1);
      if (j == 8681 || j == 17361 || j == 26041) chk("b2b_no_gap_start", {31'd0, tx_a}, 32'd0);
      if (j == 34720) chk("b2b_busy_last", {31'd0, busy_a}, 32'd1);
      if (j == 34721) chk("b2b_busy_clear", {31'd0, busy_a}, 32'd0);
    end
    chk("slow_queue_drained", q_a.size(), 32'd0);

    // 1 Mbaud: 0x00 keeps tx low for 900 cycles, frame lasts 1000.
    @(negedge clk);
    wr(1'b1, 8'h00, 1'b1);
    for (int j = 0; j <= 1001; j++) begin
      @(negedge clk);
      if (j == 0) chk("fast_tx_idle_on_accept", {31'd0, tx_b}, 32'd1);
      if (j == 1 || j == 900) chk("fast_low_span", {31'd0, tx_b}, 32'd0);
      if (j == 901) chk("fast_stop_high", {31'd0, tx_b}, 32'd1);
      if (j == 1000) chk("fast_busy_last", {31'd0, busy_b}, 32'd1);
      if (j == 1001) chk("fast_busy_clear", {31'd0, busy_b}, 32'd0);
    end

    // Fill the FIFO behind a running frame; write while full is dropped.
    wr(1'b1, 8'h11, 1'b1);
    @(posedge clk);
    @(negedge clk);
    wr(1'b1, 8'h22, 1'b1);
    wr(1'b1, 8'h33, 1'b1);
    wr(1'b1, 8'h44, 1'b1);
    wr(1'b1, 8'h55, 1'b1);
    @(negedge clk);
    chk("full_ready_low", {31'd0, ready_b}, 32'd0);
    wr(1'b1, 8'h66, 1'b0);
    @(negedge clk);
    chk("full_ready_still_low", {31'd0, ready_b}, 32'd0);
    n = 0;
    while (ready_b !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("full_ready_returns", {31'd0, ready_b}, 32'd1);
    wr(1'b1, 8'h77, 1'b1);
    wait_idle_b(8000);
    chk("full_queue_drained", q_b.size(), 32'd0);

    // Write lands on the same edge as the stop-to-start pop.
    @(negedge clk);
    wr(1'b1, 8'hA1, 1'b1);
    wr(1'b1, 8'hB2, 1'b1);
    repeat (999) @(posedge clk);
    @(negedge clk);
    chk("coin_stop_before", {31'd0, tx_b}, 32'd1);
    wr(1'b1, 8'hC3, 1'b1);
    @(negedge clk);
    chk("coin_next_start", {31'd0, tx_b}, 32'd0);
    chk("coin_ready", {31'd0, ready_b}, 32'd1);
    wait_idle_b(2500);
    chk("coin_queue_drained", q_b.size(), 32'd0);

    // Reset during data bit 3 of 0xA3 with two bytes queued.
    @(negedge clk);
    wr(1'b1, 8'hA3, 1'b1);
    wr(1'b1, 8'h5A, 1'b1);
    wr(1'b1, 8'h3C, 1'b1);
    repeat (440) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_bit3", {31'd0, tx_b}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_b}, 32'd1);
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_abort_tx", {31'd0, tx_b}, 32'd1);
    chk("rst_abort_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_abort_ready", {31'd0, ready_b}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    q_b.delete();
    quiet = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      if (tx_b !== 1'b1 || busy_b !== 1'b0) quiet = 1'b0;
    end
    chk("rst_nothing_after", {31'd0, quiet}, 32'd1);

    // Accept on the very first edge after reset is released.
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    data_b = 8'h96;
    valid_b = 1'b1;
    q_b.push_back(8'h96);
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    data_b = 'x;
    @(negedge clk);
    chk("first_edge_accept_busy", {31'd0, busy_b}, 32'd1);
    chk("first_edge_tx_idle", {31'd0, tx_b}, 32'd1);
    @(negedge clk);
    chk("first_edge_start", {31'd0, tx_b}, 32'd0);
    wait_idle_b(1200);
    repeat (5) @(negedge clk);
    chk("final_queue_drained", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
